// File: rtl/noc_port_requester.sv
// Per-input-port requester: buffers flits, decodes packet framing and drives the
// router arbiter's request interface, forwarding flits to the crossbar while granted.
module noc_port_requester #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter logic [2:0]  HDR_ID  = 3'b001,
    parameter logic [2:0]  BODY_ID = 3'b010,
    parameter logic [2:0]  TAIL_ID = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_flit_id,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic              out_valid,
    output logic [2:0]        out_flit_id,
    output logic [DATA_W-1:0] out_data,
    output logic              pkt_done,
    output logic              err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StSend, StStall} state_t;

    state_t            state_q, state_d;
    logic              req_q;
    logic [11:0]       length_q;
    logic [2:0]        mem_id   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;

    logic              empty, full, push, pop, discard;
    logic [2:0]        head_id;
    logic [DATA_W-1:0] head_data;
    logic              head_hdr, head_tail, head_body_like;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    // in_ready depends only on occupancy, so a full FIFO never pushes even while popping
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid || discard;
    assign head_id   = mem_id[rd_ptr_q];
    assign head_data = mem_data[rd_ptr_q];

    assign head_hdr       = !empty && (head_id == HDR_ID);
    assign head_tail      = !empty && (head_id == TAIL_ID);
    // Unknown IDs count as body flits
    assign head_body_like = !empty && ((head_id == BODY_ID) || !(head_id == HDR_ID ||
                            head_id == TAIL_ID));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr_q]   <= in_flit_id;
            mem_data[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            length_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (state_q == StIdle && head_hdr) length_q <= head_data[11:0];
        end
    end

    // State register; req is registered alongside it from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (head_hdr) state_d = StReq;
            StReq:   if (grant) state_d = StSend;
            StSend: begin
                if (head_hdr)                    state_d = StIdle;
                else if (!grant)                 state_d = StStall;
                else if (out_valid && head_tail) state_d = StIdle;
            end
            StStall: begin
                if (grant) state_d = (out_valid && head_tail) ? StIdle : StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid   = grant && (state_q != StIdle) && !empty &&
                      !(state_q == StSend && head_hdr);
        discard     = (state_q == StIdle) && (head_body_like || head_tail);
        err         = discard || (state_q == StSend && head_hdr);
        pkt_done    = out_valid && head_tail;
        out_flit_id = out_valid ? head_id : 3'b000;
        out_data    = out_valid ? head_data : '0;
        flit_id     = empty ? 3'b000 : head_id;
        // Arbiter needs the length in the same cycle it first sees the header
        length      = (state_q == StIdle && head_hdr) ? head_data[11:0] : length_q;
        req         = req_q;
    end

endmodule

// File: tb/tb_noc_port_requester.sv
// Bench for noc_port_requester: packet-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_noc_port_requester;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_flit_id = 3'b000;
    logic [DATA_W-1:0] in_data = '0;
    logic              grant = 1'b0;
    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              out_valid;
    logic [2:0]        out_flit_id;
    logic [DATA_W-1:0] out_data;
    logic              pkt_done;
    logic              err;

    noc_port_requester #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .HDR_ID (HDR),
        .BODY_ID(BODY),
        .TAIL_ID(TAIL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_flit_id (in_flit_id),
        .in_data    (in_data),
        .grant      (grant),
        .req        (req),
        .flit_id    (flit_id),
        .length     (length),
        .out_valid  (out_valid),
        .out_flit_id(out_flit_id),
        .out_data   (out_data),
        .pkt_done   (pkt_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        id;
        logic [DATA_W-1:0] data;
    } flit_t;

    int compared = 0;
    int mismatched = 0;

    flit_t             mq[$];
    logic              busy, started, stalled;
    logic [11:0]       len_m;
    logic [DATA_W-1:0] fwd_log[$];
    logic [DATA_W-1:0] exp_q[$];
    int                n_done = 0;
    int                n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_fwd(input string name, input int start);
        chk({name, "_count"}, 64'(fwd_log.size() - start), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i < fwd_log.size()) chk({name, "_data"}, fwd_log[start+i], exp_q[i]);
        end
    endtask

    // Reference model: the port owns a packet (busy) from header-at-head until the tail
    // leaves or a stray header aborts it; started = header sent, stalled = grant lost.
    task automatic model_loop();
        logic              empty, hdr, tl, sending, fwd, disc, e_err, e_done, e_rdy;
        logic [2:0]        hid;
        logic [DATA_W-1:0] hdat;
        logic [11:0]       e_len;
        flit_t             f;
        forever begin
            @(negedge clk);
            if (out_valid) fwd_log.push_back(out_data);
            if (pkt_done) n_done++;
            if (err) n_err++;
            if (rst) begin
                mq.delete();
                busy = 0; started = 0; stalled = 0; len_m = '0;
                chk("rst_req", req, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_flit_id", flit_id, 0);
                chk("rst_length", length, 0);
                chk("rst_pkt_done", pkt_done, 0);
                chk("rst_err", err, 0);
            end else begin
                empty = (mq.size() == 0);
                hid = 3'b000;
                hdat = '0;
                if (!empty) begin
                    hid = mq[0].id;
                    hdat = mq[0].data;
                end
                hdr     = !empty && hid == HDR;
                tl      = !empty && hid == TAIL;
                sending = busy && started && !stalled;
                e_len   = (!busy && hdr) ? hdat[11:0] : len_m;
                fwd     = grant && busy && !empty && !(sending && hdr);
                disc    = !busy && !empty && !hdr;
                e_err   = disc || (sending && hdr);
                e_done  = fwd && tl;
                e_rdy   = mq.size() < DEPTH;
                chk("req", req, busy);
                chk("flit_id", flit_id, hid);
                chk("length", length, e_len);
                chk("out_valid", out_valid, fwd);
                chk("pkt_done", pkt_done, e_done);
                chk("err", err, e_err);
                chk("in_ready", in_ready, e_rdy);
                if (fwd) begin
                    chk("out_flit_id", out_flit_id, hid);
                    chk("out_data", out_data, hdat);
                end
                if (!busy) begin
                    if (hdr) begin
                        busy = 1; started = 0; stalled = 0; len_m = hdat[11:0];
                    end
                end else if (!started) begin
                    if (grant) started = 1;
                end else if (!stalled) begin
                    if (hdr) busy = 0;
                    else if (!grant) stalled = 1;
                    else if (e_done) busy = 0;
                end else begin
                    if (grant) stalled = 0;
                    if (e_done) busy = 0;
                end
                if (fwd || disc) void'(mq.pop_front());
                if (in_valid && e_rdy) begin
                    f.id = in_flit_id;
                    f.data = in_data;
                    mq.push_back(f);
                end
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one flit and hold it until accepted, bounded.
    task automatic push(input logic [2:0] id, input logic [DATA_W-1:0] data);
        logic acc;
        int   k;
        in_valid = 1'b1;
        in_flit_id = id;
        in_data = data;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic stimulus();
        int s_log, s_done, s_err;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // 1: H(len 5), B, T with grant held high
        grant = 1'b1;
        s_log = fwd_log.size(); s_done = n_done;
        push(HDR, 32'hA100_0005);
        chk("t1_head_id", flit_id, 3'b001);
        chk("t1_head_len", length, 12'd5);
        chk("t1_req_before", req, 0);
        push(BODY, 32'hB100_0001);
        chk("t1_req_raised", req, 1);
        push(TAIL, 32'hC100_0002);
        cycles(5);
        exp_q = '{32'hA100_0005, 32'hB100_0001, 32'hC100_0002};
        chk_fwd("t1_fwd", s_log);
        chk("t1_done", n_done - s_done, 1);
        chk("t1_req_after", req, 0);

        // 2: grant lost mid-packet, req held, resume on re-grant
        grant = 1'b0;
        s_log = fwd_log.size(); s_done = n_done;
        push(HDR, 32'hA200_0006);
        push(BODY, 32'hB200_0001);
        push(BODY, 32'hB200_0002);
        push(TAIL, 32'hC200_0003);
        grant = 1'b1;
        cycles(2);
        grant = 1'b0;
        cycles(1);
        chk("t2_stall_req", req, 1);
        chk("t2_stall_nopop", out_valid, 0);
        cycles(2);
        chk("t2_stall_req2", req, 1);
        grant = 1'b1;
        cycles(5);
        exp_q = '{32'hA200_0006, 32'hB200_0001, 32'hB200_0002, 32'hC200_0003};
        chk_fwd("t2_fwd", s_log);
        chk("t2_done", n_done - s_done, 1);

        // 3: fill the FIFO, fifth flit waits upstream
        grant = 1'b0;
        s_log = fwd_log.size();
        fork
            begin
                push(HDR, 32'hA300_0007);
                push(BODY, 32'hB300_0001);
                push(BODY, 32'hB300_0002);
                push(BODY, 32'hB300_0003);
                push(TAIL, 32'hC300_00FF);
            end
            begin
                cycles(6);
                chk("t3_full_ready", in_ready, 0);
                grant = 1'b1;
            end
        join
        cycles(6);
        exp_q = '{32'hA300_0007, 32'hB300_0001, 32'hB300_0002, 32'hB300_0003, 32'hC300_00FF};
        chk_fwd("t3_fwd", s_log);

        // 4: stray body in IDLE is discarded with one err pulse
        grant = 1'b0;
        s_log = fwd_log.size(); s_err = n_err;
        push(BODY, 32'hB400_0001);
        cycles(3);
        chk("t4_err", n_err - s_err, 1);
        chk("t4_req", req, 0);
        chk("t4_fwd", fwd_log.size() - s_log, 0);
        chk("t4_empty", flit_id, 0);

        // 5: missing tail, second header aborts and is re-requested
        grant = 1'b1;
        s_log = fwd_log.size(); s_err = n_err; s_done = n_done;
        push(HDR, 32'hA500_0003);
        push(BODY, 32'hB500_0001);
        push(HDR, 32'hA510_0009);
        push(BODY, 32'hB510_0001);
        push(TAIL, 32'hC510_0002);
        cycles(8);
        exp_q = '{32'hA500_0003, 32'hB500_0001, 32'hA510_0009, 32'hB510_0001, 32'hC510_0002};
        chk_fwd("t5_fwd", s_log);
        chk("t5_err", n_err - s_err, 1);
        chk("t5_done", n_done - s_done, 1);
        chk("t5_len", length, 12'd9);

        // 6: asynchronous reset mid-SEND with three flits buffered
        grant = 1'b0;
        push(HDR, 32'hA600_0004);
        push(BODY, 32'hB600_0001);
        push(BODY, 32'hB600_0002);
        push(BODY, 32'hB600_0003);
        grant = 1'b1;
        cycles(1);
        grant = 1'b0;
        chk("t6_req_pre", req, 1);
        chk("t6_ready_pre", in_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_rst", req, 0);
        chk("t6_ov_rst", out_valid, 0);
        chk("t6_ready_rst", in_ready, 0);
        cycles(2);
        rst = 1'b0;
        cycles(1);
        chk("t6_flit_id", flit_id, 0);
        chk("t6_ready_post", in_ready, 1);
        chk("t6_req_post", req, 0);
        cycles(2);
    endtask

    initial begin
        fork
            model_loop();
            stimulus();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/noc_port_requester.md
Name: noc_port_requester

Overview:
- Per-input-port initiator that drives the router arbiter's request interface: one instance per port (L, N, E, W, S).
- Buffers incoming flits in a small FIFO and decodes packet framing from the flit ID.
- Raises req and presents flit_id/length to the arbiter for the whole packet, then forwards flits to the crossbar only while the arbiter grants this port.
- Holds req across a timeout-induced grant loss and resumes the packet when re-granted.

Parameters:
DATA_W, 32, flit payload width; must be at least 12.
DEPTH, 4, FIFO depth in flits; power of two, at least 2.
HDR_ID, 3'b001, flit ID of a header flit. The arbiter's timer loads length on this value.
BODY_ID, 3'b010, flit ID of a body flit.
TAIL_ID, 3'b100, flit ID of a tail flit.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
in_valid  in  1  upstream flit valid.
in_ready  out  1  FIFO can accept a flit.
in_flit_id  in  3  flit ID of the incoming flit.
in_data  in  DATA_W  incoming payload; on a header flit, bits [11:0] carry the packet length (timeout in clock periods).
grant  in  1  this port's bit of the arbiter's registered one-hot state.
req  out  1  request to the arbiter.
flit_id  out  3  flit ID at the FIFO head; 3'b000 when the FIFO is empty.
length  out  12  length field of the current packet.
out_valid  out  1  flit popped and driven to the crossbar this cycle.
out_flit_id  out  3  flit ID of the flit being forwarded.
out_data  out  DATA_W  payload of the flit being forwarded.
pkt_done  out  1  one-cycle pulse in the cycle a tail flit is forwarded.
err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset: asynchronous. All outputs go to 0, FIFO pointers and occupancy clear, length=0, state=IDLE. A reset mid-packet discards the buffered flits with no tail required.
- FIFO write: push when in_valid && in_ready; in_ready = !full. Because in_ready depends only on full, a full FIFO never pushes, even in a cycle that also pops.
- FIFO read: there is no bypass. A flit pushed into an empty FIFO reaches the head in the next cycle. Simultaneous push and pop when the FIFO is neither full nor empty leaves occupancy unchanged.
- length:
  - Loaded from head data[11:0] when a header flit is at the head in IDLE.
  - Held until the next header is loaded.
  - Driven combinationally from the head while a header is at the head in IDLE, so the arbiter sees flit_id=HDR_ID with a valid length.
- req is a registered decode of the state: req=1 in REQ, SEND and STALL; req=0 in IDLE.
- out_valid = grant && state!=IDLE && !empty && !(state==SEND && head is a header). When out_valid=1, the head is popped in that same cycle and out_flit_id/out_data carry it.
- State machine (registered, 4 states):
  - IDLE:
    - Header at head: load length, go to REQ (req=1 next cycle).
    - Body or tail at head: pop and discard it, err=1, stay in IDLE.
    - Empty: stay in IDLE.
  - REQ:
    - grant=0: stay in REQ.
    - grant=1: forward the header, go to SEND.
  - SEND:
    - grant=1 and FIFO non-empty: forward one flit per cycle. On forwarding a tail: pkt_done=1, go to IDLE; req falls the next cycle.
    - grant=1 and FIFO empty: bubble, stay in SEND.
    - grant=0 (arbiter timer expired or preempted): no pop, go to STALL.
    - Header at head (missing tail): err=1, header is not popped, go to IDLE; the packet is re-requested from IDLE.
  - STALL:
    - req stays 1.
    - grant=0: stay in STALL.
    - grant=1: go to SEND and forward the head in that same cycle if the FIFO is non-empty.
- Flit IDs other than HDR_ID, BODY_ID or TAIL_ID are treated as body flits.
- Single-flit packets are not supported; every packet has exactly one header and one tail, with zero or more body flits between them.

Test Plan:
1. Reset, then push H(len=12'd5), B, T with grant tied to 1 → req=1 one cycle after H reaches the head; flit_id=3'b001 and length=5 on that head cycle; out_valid on 3 consecutive cycles carrying H, B, T; pkt_done pulses on T; req=0 the following cycle.
2. Push H, B, B, T; grant=1 for 2 cycles, 0 for 3 cycles, then 1 → H and B forwarded, state=STALL with req held at 1, no pop while grant=0, remaining B and T forwarded after re-grant.
3. Push 5 flits back-to-back with DEPTH=4 and grant=0 → in_ready=0 after the 4th push, 5th flit held upstream; once grant=1 and a pop occurs, in_ready rises and the 5th flit is accepted intact.
4. Push a B flit while in IDLE → popped and discarded, err pulses once, req stays 0.
5. Push H, B, H2(len=9), B, T → err pulses when H2 reaches the head in SEND; state returns to IDLE; length=9 and req is re-asserted for the second packet.
6. Assert rst asynchronously mid-SEND with 3 flits buffered → req, out_valid and in_ready go to 0 immediately; after release, flit_id=3'b000 and the FIFO is empty.
